// File: rtl/alu_bist.sv
// Built-in self-test engine for the combinational ALU: applies eight directed
// vectors, samples result and zero flag, and reports mismatch count and first failure.
module alu_bist #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  operation,
    output logic [31:0] ALU_in_X,
    output logic [31:0] ALU_in_Y,
    input  logic [31:0] ALU_out_S,
    input  logic        ZR,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_count,
    output logic [2:0]  first_fail,
    output logic [2:0]  vector_index
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] s;
    } vec_t;

    function automatic vec_t rom(input logic [2:0] idx);
        case (idx)
            3'd0:    rom = '{OP_ADD, 32'h0000_0A05, 32'h0000_0618, 32'h0000_101D};
            3'd1:    rom = '{OP_AND, 32'h0000_0A05, 32'h0000_0618, 32'h0000_0200};
            3'd2:    rom = '{OP_SUB, 32'h0000_0A05, 32'h0000_0618, 32'h0000_03ED};
            3'd3:    rom = '{OP_SUB, 32'h0000_0A05, 32'hFFFF_F218, 32'h0000_17ED};
            3'd4:    rom = '{OP_SUB, 32'h0000_0A05, 32'h0000_0DE8, 32'hFFFF_FC1D};
            3'd5:    rom = '{OP_OR,  32'h0000_0A05, 32'h0000_0618, 32'h0000_0E1D};
            3'd6:    rom = '{OP_NOR, 32'h0000_0A05, 32'h0000_0618, 32'hFFFF_F1E2};
            default: rom = '{OP_SLT, 32'h0000_0A05, 32'h0000_0618, 32'h0000_0000};
        endcase
    endfunction

    state_t     state, state_nxt;
    logic [3:0] settle_cnt;
    vec_t       cur_vec, next_vec;
    logic       vec_fail, last_vec, settle_end;

    assign cur_vec    = rom(vector_index);
    assign next_vec   = rom(vector_index + 3'd1);
    assign vec_fail   = (ALU_out_S != cur_vec.s) || (ZR != (cur_vec.s == 32'd0));
    assign last_vec   = (vector_index == 3'd7);
    assign settle_end = (settle_cnt == 4'(SETTLE_CYCLES - 1));

    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (fail_count == 4'd0);

    // NOTE: assign a default to every always_comb output first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = SETTLE;
            SETTLE:     if (settle_end) state_nxt = CHECK;
            CHECK:      state_nxt = last_vec ? DONE : SETTLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            operation    <= '0;
            ALU_in_X     <= '0;
            ALU_in_Y     <= '0;
            fail_count   <= '0;
            first_fail   <= '0;
            vector_index <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        operation    <= rom(3'd0).op;
                        ALU_in_X     <= rom(3'd0).x;
                        ALU_in_Y     <= rom(3'd0).y;
                        vector_index <= 3'd0;
                        fail_count   <= '0;
                        first_fail   <= '0;
                        settle_cnt   <= '0;
                    end
                end
                SETTLE: settle_cnt <= settle_cnt + 4'd1;
                CHECK: begin
                    if (vec_fail) begin
                        fail_count <= fail_count + 4'd1;
                        if (fail_count == 4'd0) first_fail <= vector_index;
                    end
                    if (!last_vec) begin
                        operation    <= next_vec.op;
                        ALU_in_X     <= next_vec.x;
                        ALU_in_Y     <= next_vec.y;
                        vector_index <= vector_index + 3'd1;
                        settle_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test engine for the combinational ALU: it drives a fixed set of eight directed vectors into the ALU, then samples and checks each result (`ALU_out_S`) and zero flag (`ZR`). It counts mismatches and reports pass/fail once the sequence completes. It sits beside the ALU in the core: a top-level mux selects this block or the datapath as the ALU source, and it is used for power-on and FPGA bring-up checks.

## Interface
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling; legal range 1..15.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  start pulse; sampled only in IDLE or DONE
- `operation`  out  4  ALU operation code driven to the ALU
- `ALU_in_X`  out  32  operand A driven to the ALU
- `ALU_in_Y`  out  32  operand B driven to the ALU
- `ALU_out_S`  in  32  ALU result
- `ZR`  in  1  ALU zero flag
- `busy`  out  1  high while vectors are being applied
- `done`  out  1  high in DONE state
- `pass`  out  1  `done` && `fail_count`==0
- `fail_count`  out  4  number of failing vectors, 0..8
- `first_fail`  out  3  index of first failing vector; valid when `fail_count`!=0
- `vector_index`  out  3  index of the vector currently driven

## Operation
- Operation codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
- Vector ROM, as index: op, X, Y, expected S (hex):
  - 0: ADD, 0xA05, 0x618, 0x0000101D
  - 1: AND, 0xA05, 0x618, 0x00000200
  - 2: SUB, 0xA05, 0x618, 0x000003ED
  - 3: SUB, 0xA05, 0xFFFFF218, 0x000017ED
  - 4: SUB, 0xA05, 0xDE8, 0xFFFFFC1D
  - 5: OR, 0xA05, 0x618, 0x00000E1D
  - 6: NOR, 0xA05, 0x618, 0xFFFFF1E2
  - 7: SLT, 0xA05, 0x618, 0x00000000
- Expected `ZR` = (expected S == 0). Only vector 7 expects `ZR`=1.
- A vector fails if S mismatches, `ZR` mismatches, or both; each failing vector counts once.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE: `start`=1 → load vector 0 into the output registers, clear `fail_count`/`first_fail`, reset the settle counter → SETTLE.
  - SETTLE: counter increments each cycle; at counter==`SETTLE_CYCLES`-1 → CHECK.
  - CHECK: compare inputs against the ROM and update the counters.
    - If `vector_index`<7: load the next vector → SETTLE.
    - Otherwise → DONE.
  - DONE: hold the results; `start`=1 restarts exactly as from IDLE (results cleared on that edge).
- `start` is ignored in SETTLE and CHECK.
- `first_fail` is written only when the first failure is recorded (`fail_count` 0→1).
- `operation`/`ALU_in_X`/`ALU_in_Y` are registered. They hold the last vector in DONE and are zero in IDLE.

## Timing
- Reset value of all outputs: 0. State IDLE; `busy`=0, `done`=0, `pass`=0.
- `reset` wins over any state, including mid-sequence. The next edge after deassertion sees IDLE, with no partial results kept.
- Start edge E0 → vector 0 on the ALU ports from E0+, `busy`=1.
- Each vector occupies `SETTLE_CYCLES`+1 cycles. Sampling happens on the CHECK edge, and the next vector appears right after it.
- `done` rises after edge E0+8·(`SETTLE_CYCLES`+1), which is 16 cycles for the default. `busy` falls on the same edge.
- `fail_count` updates on the CHECK edge of the failing vector and saturates naturally at 8.
- `pass` is combinational from the registered `done` and `fail_count`.

## Test plan
- Reset, then pulse `start` with the real ALU attached → `done` 16 cycles after start, `pass`=1, `fail_count`=0, `busy` high for exactly 16 cycles.
- ALU model with SUB result forced to +1 → `fail_count`=3, `first_fail`=2, `pass`=0.
- `ZR` forced to constant 0 → only vector 7 fails: `fail_count`=1, `first_fail`=7.
- `SETTLE_CYCLES`=3 → `done` at start+32. Each vector is held 4 cycles; check `vector_index` stepping 0..7.
- `reset` asserted at cycle 7 of a run → all outputs 0 next cycle. A fresh `start` then completes normally with `pass`=1.
- `start` pulsed during SETTLE → ignored, timing unchanged. `start` pulsed in DONE → results cleared and the sequence reruns.
